// File: rtl/gru_weight_fetch.sv
// Read sequencer for the GRU parameter RAM: walks weights then biases, streams words out through a small FIFO.
// Define GRU_FETCH_BIAS_EN to include the bias phase; otherwise only the weight region is fetched.
module gru_weight_fetch #(
    parameter int AWL     = 7,
    parameter int DWL     = 144,
    parameter int W_BASE  = 0,
    parameter int W_COUNT = 96,
    parameter int B_BASE  = 96,
    parameter int B_COUNT = 16,
    parameter int FDEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           ram_en,
    output logic [AWL-1:0] ram_addr,
    input  logic [DWL-1:0] ram_dout,
    output logic [DWL-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_is_bias,
    output logic           m_last
);
    localparam int PW = $clog2(FDEPTH);
    localparam logic [31:0]    W_LAST   = 32'(W_COUNT) - 32'd1;
    localparam logic [31:0]    B_LAST   = 32'(B_COUNT) - 32'd1;
    localparam logic [AWL-1:0] W_BASE_A = AWL'(W_BASE);
    localparam logic [AWL-1:0] B_BASE_A = AWL'(B_BASE);

`ifdef GRU_FETCH_BIAS_EN
    localparam logic HAS_BIAS = (B_COUNT != 0);
    typedef enum logic [2:0] {IDLE, WEIGHTS, BIAS, DRAIN, DONE} state_t;
`else
    localparam logic HAS_BIAS = 1'b0;
    typedef enum logic [2:0] {IDLE, WEIGHTS, DRAIN, DONE} state_t;
`endif

    state_t state, next_state;

    logic [31:0]     cnt;
    logic [AWL-1:0]  cur_addr, addr_q;
    logic            inflight, tag_bias_q, tag_last_q;
    logic            in_bias, issuing, credit_ok, phase_last, issue_last;
    logic            push, pop;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     occ;
    logic [PW+1:0]   used;
    logic [DWL+1:0]  mem [FDEPTH];
    logic [DWL+1:0]  head;

`ifdef GRU_FETCH_BIAS_EN
    assign in_bias = (state == BIAS);
`else
    assign in_bias = 1'b0;
`endif

    // Credit uses the pre-pop occupancy, so a slot freed by this cycle's pop is only usable next cycle
    assign issuing    = (state == WEIGHTS) || in_bias;
    assign used       = {1'b0, occ} + {{(PW+1){1'b0}}, inflight};
    assign credit_ok  = used < (PW+2)'(FDEPTH);
    assign ram_en     = issuing && credit_ok;
    assign ram_addr   = ram_en ? cur_addr : addr_q;
    assign phase_last = (state == WEIGHTS) ? (cnt == W_LAST) : (cnt == B_LAST);
    assign issue_last = phase_last && (in_bias || !HAS_BIAS);

    assign push = inflight;
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // An empty pass still spends one busy cycle in DRAIN, so done lands two cycles after start
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
`ifdef GRU_FETCH_BIAS_EN
                if (W_COUNT != 0)  next_state = WEIGHTS;
                else if (HAS_BIAS) next_state = BIAS;
                else               next_state = DRAIN;
`else
                next_state = (W_COUNT != 0) ? WEIGHTS : DRAIN;
`endif
            end
`ifdef GRU_FETCH_BIAS_EN
            WEIGHTS: if (ram_en && phase_last) next_state = HAS_BIAS ? BIAS : DRAIN;
            BIAS:    if (ram_en && phase_last) next_state = DRAIN;
`else
            WEIGHTS: if (ram_en && phase_last) next_state = DRAIN;
`endif
            DRAIN:   if (!inflight && (occ == {{PW{1'b0}}, pop})) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cur_addr   <= '0;
            addr_q     <= '0;
            inflight   <= 1'b0;
            tag_bias_q <= 1'b0;
            tag_last_q <= 1'b0;
        end else begin
            inflight <= ram_en;
            if (ram_en) begin
                addr_q     <= cur_addr;
                tag_bias_q <= in_bias;
                tag_last_q <= issue_last;
            end
            if (state == IDLE && start) begin
                cnt      <= '0;
                cur_addr <= (W_COUNT != 0) ? W_BASE_A : B_BASE_A;
            end else if (ram_en) begin
                if (phase_last) begin
                    cnt      <= '0;
                    cur_addr <= B_BASE_A;
                end else begin
                    cnt      <= cnt + 32'd1;
                    cur_addr <= cur_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tag_last_q, tag_bias_q, ram_dout};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head    = mem[rd_ptr];
    assign m_valid = (occ != '0);
    assign {m_last, m_is_bias, m_data} = m_valid ? head : '0;

endmodule
